// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction-memory responder: response entry layout,
// grant FSM encoding and the fill word used for unused memory locations.
package instr_mem_pkg;

    localparam int          RESP_DATA_W = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } gnt_state_t;

    typedef struct packed {
        logic [RESP_DATA_W-1:0] rdata;
        logic [3:0]             countdown;
        logic                   err;
    } resp_entry_t;

    // Countdown step that stops at zero so a ready head stays ready.
    function automatic logic [3:0] dec_sat(input logic [3:0] v);
        return (v == 4'd0) ? v : v - 4'd1;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response queue. Every stored entry counts its own latency down each
// cycle; the head may leave once its countdown has reached zero.
module resp_fifo
    import instr_mem_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = resp_entry_t,
    localparam int CNT_W   = $clog2(DEPTH) + 1,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    output entry_t           head,
    output logic             head_ready,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    entry_t           slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entry storage: free-running countdown on every slot; a push overwrites its slot.
    // Stale slots also count down, which is harmless since they are rewritten before use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            slots[i].countdown <= dec_sat(slots[i].countdown);
        end
        if (push) begin
            slots[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head       = slots[rd_ptr];
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign head_ready = !empty && (head.countdown == 4'd0);

endmodule

// File: rtl/instr_mem_responder.sv
// Slave model of the core instruction-fetch port. Grants after a programmable
// number of request cycles, returns array data a fixed number of cycles after
// each grant, in order, with a bounded number of fetches in flight.
// Optional build macro INSTR_MEM_RESP_ERR_EN adds instr_err for fetches whose
// word index lies above the array; without it such addresses alias.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no request pending, delay counter at zero
// WAIT_GNT | request seen, counting held cycles until the grant condition
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH = 16,
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int MEM_DEPTH_WORDS  = 1024,
    parameter int RVALID_LATENCY   = 2,
    parameter int MAX_OUTSTANDING  = 4,
    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS),
    localparam int OCC_W = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        instr_req,
    input  logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
    output logic                        instr_gnt,
    output logic                        instr_rvalid,
    output logic [INSTR_DATA_WIDTH-1:0] instr_rdata,
    input  logic [3:0]                  cfg_gnt_delay,
    input  logic                        load_we,
    input  logic [IDX_W-1:0]            load_addr,
    input  logic [INSTR_DATA_WIDTH-1:0] load_wdata,
    output logic [OCC_W-1:0]            outstanding,
    output logic [31:0]                 grant_count
`ifdef INSTR_MEM_RESP_ERR_EN
    ,
    output logic                        instr_err
`endif
);

    localparam int WADDR_W = INSTR_ADDR_WIDTH - 2;

    logic [INSTR_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

    gnt_state_t               state;
    gnt_state_t               state_nxt;
    logic [3:0]               delay_cnt;
    logic [3:0]               delay_nxt;
    logic [WADDR_W-1:0]       word_addr;
    logic [IDX_W-1:0]         word_idx;
    logic [WADDR_W-IDX_W-1:0] word_hi;
    resp_entry_t              push_entry;
    resp_entry_t              q_head;
    logic                     q_pop;
    logic                     q_full;
    logic                     q_empty;
    logic                     unused_bits;

    assign word_addr = instr_addr[INSTR_ADDR_WIDTH-1:2];
    assign word_idx  = word_addr[IDX_W-1:0];
    assign word_hi   = word_addr[WADDR_W-1:IDX_W];

    // Preload port; the grant path reads the pre-write contents in the same cycle.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_wdata;
        end
    end

    // Grant FSM state and held-request counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            delay_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            delay_cnt <= delay_nxt;
        end
    end

    // Grant decision; a head leaving this cycle frees a slot for a new grant.
    always_comb begin
        state_nxt = state;
        delay_nxt = delay_cnt;
        instr_gnt = instr_req && (delay_cnt >= cfg_gnt_delay) && (!q_full || q_pop);
        unique case (state)
            IDLE: begin
                if (instr_req) begin
                    state_nxt = WAIT_GNT;
                    delay_nxt = instr_gnt ? 4'd0 : 4'd1;
                end
            end
            WAIT_GNT: begin
                if (!instr_req) begin
                    state_nxt = IDLE;
                    delay_nxt = 4'd0;
                end else if (instr_gnt) begin
                    delay_nxt = 4'd0;
                end else if (delay_cnt != 4'hF) begin
                    delay_nxt = delay_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                delay_nxt = 4'd0;
            end
        endcase
    end

    // Entry captured at the grant edge.
    always_comb begin
        push_entry           = '0;
        push_entry.countdown = 4'(RVALID_LATENCY - 1);
`ifdef INSTR_MEM_RESP_ERR_EN
        push_entry.err       = |word_hi;
        push_entry.rdata     = push_entry.err ? '0 : mem[word_idx];
`else
        push_entry.rdata     = mem[word_idx];
`endif
    end

    resp_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .entry_t (resp_entry_t)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (instr_gnt),
        .push_entry (push_entry),
        .pop        (q_pop),
        .head       (q_head),
        .head_ready (q_pop),
        .full       (q_full),
        .empty      (q_empty),
        .count      (outstanding)
    );

    // Response register: one rvalid per ready head, data held between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_rvalid <= 1'b0;
            instr_rdata  <= '0;
`ifdef INSTR_MEM_RESP_ERR_EN
            instr_err    <= 1'b0;
`endif
        end else begin
            instr_rvalid <= q_pop;
            if (q_pop) begin
                instr_rdata <= q_head.rdata;
            end
`ifdef INSTR_MEM_RESP_ERR_EN
            instr_err    <= q_pop && q_head.err;
`endif
        end
    end

    // Wrapping grant counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_count <= '0;
        end else if (instr_gnt) begin
            grant_count <= grant_count + 32'd1;
        end
    end

`ifdef INSTR_MEM_RESP_ERR_EN
    assign unused_bits = ^{instr_addr[1:0], q_head.countdown, q_empty};
`else
    assign unused_bits = ^{instr_addr[1:0], word_hi, q_head.countdown, q_head.err, q_empty};
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomised scoreboard bench for instr_mem_responder. The reference model
// tracks each fetch by the clock edge on which its response must appear.
module tb_instr_mem_responder;
    import instr_mem_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 5;
    localparam int MAXO  = 4;
    localparam int IDXW  = 10;
    localparam int OCCW  = 3;

    logic            clk           = 1'b0;
    logic            rst_n         = 1'b0;
    logic            instr_req     = 1'b0;
    logic [AW-1:0]   instr_addr    = '0;
    logic [3:0]      cfg_gnt_delay = '0;
    logic            load_we       = 1'b0;
    logic [IDXW-1:0] load_addr     = '0;
    logic [DW-1:0]   load_wdata    = '0;
    logic            instr_gnt;
    logic            instr_rvalid;
    logic [DW-1:0]   instr_rdata;
    logic [OCCW-1:0] outstanding;
    logic [31:0]     grant_count;
`ifdef INSTR_MEM_RESP_ERR_EN
    logic            instr_err;
`endif

    always #5 clk = ~clk;

    instr_mem_responder #(
        .INSTR_ADDR_WIDTH (AW),
        .INSTR_DATA_WIDTH (DW),
        .MEM_DEPTH_WORDS  (DEPTH),
        .RVALID_LATENCY   (LAT),
        .MAX_OUTSTANDING  (MAXO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_req     (instr_req),
        .instr_addr    (instr_addr),
        .instr_gnt     (instr_gnt),
        .instr_rvalid  (instr_rvalid),
        .instr_rdata   (instr_rdata),
        .cfg_gnt_delay (cfg_gnt_delay),
        .load_we       (load_we),
        .load_addr     (load_addr),
        .load_wdata    (load_wdata),
        .outstanding   (outstanding),
        .grant_count   (grant_count)
`ifdef INSTR_MEM_RESP_ERR_EN
        ,
        .instr_err     (instr_err)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          pop_edge;
    } exp_t;

    exp_t        exp_q[$];
    int          pend[$];
    logic [31:0] mem_model [DEPTH];
    int          cyc        = 0;
    int          last_pop   = 0;
    int          held       = 0;
    logic [31:0] gcount     = '0;
    bit          last_gnt   = 1'b0;
    logic [31:0] hold_rdata = '0;
    bit          mon_en     = 1'b0;
    int          checks     = 0;
    int          passes     = 0;
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic exp_t lookup(input logic [AW-1:0] a);
        exp_t r;
        int   w;
        w          = int'(a[AW-1:2]);
        r.pop_edge = 0;
`ifdef INSTR_MEM_RESP_ERR_EN
        r.err  = (w >= DEPTH);
        r.data = r.err ? 32'h0 : mem_model[w];
`else
        r.err  = 1'b0;
        r.data = mem_model[w % DEPTH];
`endif
        return r;
    endfunction

    // One clock: compare grant/occupancy/counter, advance the model, then move past the edge.
    task automatic step();
        bit   pop_now;
        bit   g;
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n) begin
            while (pend.size() > 0 && pend[0] <= cyc) void'(pend.pop_front());
            pop_now = (pend.size() > 0) && (pend[0] == cyc + 1);
            g = instr_req && (held >= int'(cfg_gnt_delay)) && ((pend.size() < MAXO) || pop_now);
            chk("gnt", 64'(instr_gnt), 64'(g));
            chk("outstanding", 64'(outstanding), 64'(pend.size()));
            chk("grant_count", 64'(grant_count), 64'(gcount));
            if (g) begin
                e          = lookup(instr_addr);
                e.pop_edge = (cyc + 1 + LAT > last_pop + 1) ? cyc + 1 + LAT : last_pop + 1;
                last_pop   = e.pop_edge;
                exp_q.push_back(e);
                pend.push_back(e.pop_edge);
                gcount++;
                held = 0;
            end else if (instr_req) begin
                held++;
            end else begin
                held = 0;
            end
            last_gnt = g;
        end else begin
            pend.delete();
            exp_q.delete();
            held       = 0;
            gcount     = '0;
            last_gnt   = 1'b0;
            hold_rdata = '0;
            last_pop   = cyc + 1;
        end
        if (load_we) mem_model[load_addr] = load_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Raise req on an address and hold it until the model grants; returns cycles waited.
    task automatic fetch(input logic [AW-1:0] a, output int waited);
        instr_req  = 1'b1;
        instr_addr = a;
        waited     = 0;
        do begin
            step();
            waited++;
        end while (!last_gnt && waited < 40);
        if (!last_gnt) begin
            checks++;
            $display("FAIL fetch_timeout: got no grant for addr %h expected one within 40 cycles", a);
        end
        instr_req = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [3:0] hi;
        logic [9:0] w;
        logic [1:0] lo;
        hi = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        w  = 10'($urandom_range(0, 63));
        lo = 2'($urandom_range(0, 3));
        return {hi, w, lo};
    endfunction

    // Response monitor: pops the scoreboard on every rvalid, flags late or stray responses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (instr_rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL rvalid_unexpected: got rdata %h expected no response", instr_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rvalid_edge", 64'(cyc), 64'(mon_e.pop_edge));
                    chk("rdata", 64'(instr_rdata), 64'(mon_e.data));
`ifdef INSTR_MEM_RESP_ERR_EN
                    chk("err", 64'(instr_err), 64'(mon_e.err));
`endif
                    hold_rdata = mon_e.data;
                end
            end else begin
                chk("rdata_hold", 64'(instr_rdata), 64'(hold_rdata));
`ifdef INSTR_MEM_RESP_ERR_EN
                chk("err_idle", 64'(instr_err), 64'(0));
`endif
                if (exp_q.size() > 0 && exp_q[0].pop_edge <= cyc) begin
                    checks++;
                    $display("FAIL rvalid_missing: got no rvalid expected data %h at edge %0d",
                             exp_q[0].data, exp_q[0].pop_edge);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected one before 200000 ns");
        $fatal(1);
    end

    initial begin
        int w;
        int waits[12];
        int n;

        rst_n = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        chk("reset_outstanding", 64'(outstanding), 64'(0));
        chk("reset_grant_count", 64'(grant_count), 64'(0));
        chk("reset_rvalid", 64'(instr_rvalid), 64'(0));
        chk("reset_rdata", 64'(instr_rdata), 64'(0));

        for (int i = 0; i < 64; i++) begin
            load_we    = 1'b1;
            load_addr  = 10'(i);
            load_wdata = (i % 4 == 0) ? NOP_INSTR : $urandom;
            if (i == 5) load_wdata = 32'hDEAD_BEEF;
            if (i == 3) load_wdata = 32'h2222_2222;
            step();
        end
        load_we = 1'b0;

        cfg_gnt_delay = 4'd0;
        fetch(16'h0014, w);
        chk("t1_gnt_same_cycle", 64'(w), 64'(1));
        idle(LAT + 2);

        cfg_gnt_delay = 4'd3;
        fetch(16'h0020, w);
        chk("t2_gnt_4th_cycle", 64'(w), 64'(4));
        idle(LAT + 2);

        cfg_gnt_delay = 4'd15;
        fetch(16'h0024, w);
        chk("t2_gnt_delay15", 64'(w), 64'(16));
        idle(LAT + 2);

        cfg_gnt_delay = 4'd0;
        for (int i = 0; i < 12; i++) begin
            fetch(AW'(i * 4), waits[i]);
        end
        chk("t3_first_back_to_back", 64'(waits[3]), 64'(1));
        chk("t3_full_stall", 64'(waits[4]), 64'(2));
        chk("t3_grant_on_pop", 64'(waits[5]), 64'(1));
        idle(LAT + 6);

        instr_req  = 1'b1;
        instr_addr = 16'h000C;
        load_we    = 1'b1;
        load_addr  = 10'd3;
        load_wdata = 32'h1111_1111;
        step();
        instr_req = 1'b0;
        load_we   = 1'b0;
        idle(2);
        fetch(16'h000C, w);
        idle(LAT + 2);

        fetch(16'h0000, w);
        fetch(16'h0004, w);
        fetch(16'h0008, w);
        chk("t5_pre_reset_outstanding", 64'(outstanding), 64'(3));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_reset_outstanding", 64'(outstanding), 64'(0));
        chk("t5_reset_grant_count", 64'(grant_count), 64'(0));
        idle(LAT + 3);
        fetch(16'h0014, w);
        idle(LAT + 2);

        fetch(16'h1000, w);
        idle(LAT + 2);

        for (int it = 0; it < 500; it++) begin
            if (!instr_req || last_gnt) begin
                instr_req  = ($urandom_range(0, 3) != 0);
                instr_addr = rand_addr();
            end else if ($urandom_range(0, 29) == 0) begin
                instr_req = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) cfg_gnt_delay = 4'($urandom_range(0, 4));
            load_we    = ($urandom_range(0, 4) == 0);
            load_addr  = 10'($urandom_range(0, 63));
            load_wdata = $urandom;
            step();
        end
        instr_req = 1'b0;
        load_we   = 1'b0;

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        step();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Slave-side model of the core instruction-fetch interface (req/gnt/rvalid/rdata).
- Answers core fetch requests from an internal word array, with programmable grant delay, fixed response latency, in-order return and bounded outstanding requests.
- Sits on the fetch interface in FPGA and simulation builds, driving exactly the signals the IF tracking logic observes, so fetch timing is reproducible.
- Array is preloaded through a simple write port.

Parameters:
- INSTR_ADDR_WIDTH, 16, byte address width.
- INSTR_DATA_WIDTH, 32, fetch word width.
- MEM_DEPTH_WORDS, 1024, array depth; power of two.
- RVALID_LATENCY, 2, cycles from grant edge to rvalid; legal range 1..15.
- MAX_OUTSTANDING, 4, response queue depth; power of two, at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr_req  in  1  fetch request; held by core until granted
- instr_addr  in  INSTR_ADDR_WIDTH  byte address, sampled at grant
- instr_gnt  out  1  grant; combinational from req and internal state
- instr_rvalid  out  1  response valid, registered
- instr_rdata  out  INSTR_DATA_WIDTH  response data, registered
- cfg_gnt_delay  in  4  cycles req must be held before grant
- load_we  in  1  array write strobe
- load_addr  in  $clog2(MEM_DEPTH_WORDS)  word index
- load_wdata  in  INSTR_DATA_WIDTH  write data
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  queue occupancy
- grant_count  out  32  grants since reset, wrapping

Behaviour:
- Reset (rst_n low at posedge): queue emptied, delay counter 0, instr_rvalid 0, instr_rdata 0, outstanding 0, grant_count 0. Array contents are retained.
- Grant FSM:
  - IDLE: on instr_req go to WAIT_GNT.
  - WAIT_GNT: delay_cnt increments each cycle req is high.
  - instr_gnt = instr_req && (delay_cnt >= cfg_gnt_delay) && queue not full. With cfg_gnt_delay=0, gnt is high in the same cycle req first rises.
  - Grant edge = posedge with req && gnt. At a grant edge, delay_cnt clears. Next state is WAIT_GNT if req is still high, else IDLE.
  - If req drops without a grant (protocol violation), delay_cnt clears and the FSM returns to IDLE.
  - cfg_gnt_delay is sampled combinationally; changing it mid-wait affects the current request.
- Grant push: each grant pushes one entry. The entry holds the data read from array[instr_addr[INSTR_ADDR_WIDTH-1:2] mod MEM_DEPTH_WORDS] at the grant edge, plus a countdown = RVALID_LATENCY-1. instr_addr[1:0] is ignored.
- Countdown: all valid entries decrement each cycle, saturating at 0.
- Response: when the head countdown is 0, the next posedge sets instr_rvalid=1, drives instr_rdata from the head and pops it. instr_rvalid is otherwise 0 and instr_rdata holds its last value.
  - Unstalled fetch: rvalid is exactly RVALID_LATENCY cycles after the grant edge.
  - Stalled fetch (earlier response pending): one rvalid per cycle, in grant order.
- Full queue: gnt is held low. A push and a pop in the same cycle is allowed, so a full queue that pops this cycle may grant this cycle; gnt considers the pop.
- outstanding is registered occupancy after push/pop.
- Load port: a write at posedge updates the array. A grant in the same cycle to the same word returns the OLD data (read-before-write). load_we is legal during traffic.
- Reset mid-operation discards queued responses; no rvalid for them after reset.

Optional Feature:
- Macro INSTR_MEM_RESP_ERR_EN.
- Defined:
  - Adds output instr_err (1 bit, registered, reset 0), asserted alongside instr_rvalid.
  - Set when the granted word index is >= MEM_DEPTH_WORDS, i.e. address bits above the array range are nonzero; those responses return rdata 0.
- Undefined: no instr_err port; out-of-range addresses alias modulo MEM_DEPTH_WORDS.

Decomposition:
- Package instr_mem_pkg:
  - resp_entry_t struct {rdata, countdown[3:0], err}
  - FSM enum {IDLE, WAIT_GNT}
  - constant NOP_INSTR = 32'h00000013 for bench fill.
- Sub-module resp_fifo: synchronous FIFO parameterised on depth and entry type.
  - Push/pop ports, full/empty/count outputs.
  - Per-entry countdown decrement inside it; head_ready flag out.

Test Plan:
- Latency 2, cfg_gnt_delay=0, load word 5=0xDEADBEEF, req addr 0x14 held 1 cycle -> gnt same cycle, rvalid rdata 0xDEADBEEF 2 cycles after grant edge, grant_count=1.
- cfg_gnt_delay=3, req held -> gnt first high on 4th cycle of req; single rvalid 2 cycles later.
- Req held continuously, addrs 0,4,8,...; MAX_OUTSTANDING=4, latency 8 -> 4 grants back-to-back, gnt low while outstanding=4; rvalids in order; next grant in the cycle of the first pop.
- load_we to word 3=0x11111111 while granting addr 0xC, old 0x22222222 -> rvalid returns 0x22222222; a later fetch returns 0x11111111.
- Reset asserted with 3 outstanding -> no rvalid after reset, outstanding=0, grant_count=0, array data still readable.
- INSTR_MEM_RESP_ERR_EN, MEM_DEPTH_WORDS=1024, fetch 0x1000 -> instr_err=1 with rvalid, rdata 0; without macro, same fetch returns word 0.
